fifo_burst_drain: RTL and testbench

- Downstream stage of the 32-bit x 16-entry synchronous FIFO.
- Pops the FIFO through its rd_en/empty/rd_data port and re-presents the words on a valid/ready master stream.
- Groups the words into fixed-length bursts, marking the final word of each burst with m_last.
- Holds the popped words in a 2-entry skid buffer. This absorbs the FIFO's 1-cycle registered read latency and sustains 1 word/cycle.

---
 rtl/fifo_burst_drain.sv | 58 +++++
 tb/tb_fifo_burst_drain.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain: pops a registered-read FIFO into a 2-entry skid buffer and streams it out as fixed-length bursts.
module fifo_burst_drain #(
  parameter int DW = 32,
  parameter int BURST_LEN = 4,
  parameter int PKT_CW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DW-1:0]     fifo_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DW-1:0]     m_data,
  output logic              m_last,
  output logic [PKT_CW-1:0] pkt_cnt
);
  localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  logic [1:0]    occ;
  logic          inflight;
  logic          head;
  logic          tail;
  logic [DW-1:0] mem [2];
  logic [BW-1:0] beat;
  logic          xfer;
  assign m_valid = occ != 2'd0;
  assign m_data  = mem[head];
  assign m_last  = m_valid && beat == LAST_BEAT;
  assign xfer    = m_valid && m_ready;
  // An in-flight word already owns a slot, so it counts against the 2-entry budget.
  assign fifo_rd_en = rst_n && enable && !fifo_empty && (occ + {1'b0, inflight} - {1'b0, xfer}) < 2'd2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      head     <= 1'b0;
      tail     <= 1'b0;
      beat     <= '0;
      pkt_cnt  <= '0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      inflight <= fifo_rd_en;
      occ      <= occ + {1'b0, inflight} - {1'b0, xfer};
      if (inflight) begin
        mem[tail] <= fifo_rd_data;
        tail      <= ~tail;
      end
      if (xfer) begin
        head <= ~head;
        beat <= m_last ? '0 : beat + 1'b1;
        if (m_last) pkt_cnt <= pkt_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb_fifo_burst_drain: directed scenarios against a registered-read FIFO model feeding fifo_burst_drain.
module tb_fifo_burst_drain;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_last;
  logic [15:0] pkt_cnt;
  logic [31:0] mem [128];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [32:0] obs [128];
  int          n_obs = 0;
  int          errors = 0;
  int          checks = 0;

  fifo_burst_drain #(.DW(32), .BURST_LEN(4), .PKT_CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: one-cycle registered read, empty flag follows the pointers.
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Record every accepted output word as {last, data}.
  always @(posedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      obs[n_obs] <= {m_last, m_data};
      n_obs <= n_obs + 1;
    end
  end

  task automatic push(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    m_ready = 1'b1;
    #1;
    checks++;
    if ({m_valid, m_last, fifo_rd_en} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got v/l/rd=%b expected 000", {m_valid, m_last, fifo_rd_en});
    end
    checks++;
    if (m_data !== 32'h0 || pkt_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: got data=%h pkt=%0d expected 0/0", m_data, pkt_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      checks++;
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || pkt_cnt !== 16'h0) begin
        errors++;
        $display("FAIL idle k=%0d: got rd=%b v=%b pkt=%0d expected 0/0/0", k, fifo_rd_en, m_valid, pkt_cnt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 8; i++) push(32'h100 + 32'(i));
    m_ready = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      checks++;
      if (fifo_rd_en !== (k < 8)) begin
        errors++;
        $display("FAIL stream_rd k=%0d: got %b expected %b", k, fifo_rd_en, k < 8);
      end
      checks++;
      if (m_valid !== (k >= 2 && k <= 9)) begin
        errors++;
        $display("FAIL stream_valid k=%0d: got %b expected %b", k, m_valid, k >= 2 && k <= 9);
      end
      if (k >= 2 && k <= 9) begin
        checks++;
        if (m_data !== 32'h100 + 32'(k - 2) || m_last !== (k == 5 || k == 9)) begin
          errors++;
          $display("FAIL stream_data k=%0d: got %h/%b expected %h/%b", k, m_data, m_last, 32'h100 + 32'(k - 2), k == 5 || k == 9);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (pkt_cnt !== 16'd2) begin
      errors++;
      $display("FAIL stream_pkt: got %0d expected 2", pkt_cnt);
    end
  endtask

  task automatic test_stall();
    int nx;
    int base_rd;
    int base_obs;
    logic [32:0] exp;
    do_reset();
    nx = 0;
    base_rd = rd_ptr;
    base_obs = n_obs;
    for (int i = 0; i < 8; i++) push(32'h100 + 32'(i));
    enable = 1'b1;
    for (int k = 0; k < 30; k++) begin
      m_ready = (k % 2 == 0);
      #1;
      if (m_valid) begin
        checks++;
        if (m_data !== 32'h100 + 32'(nx) || m_last !== (nx % 4 == 3)) begin
          errors++;
          $display("FAIL stall_data k=%0d: got %h/%b expected %h/%b", k, m_data, m_last, 32'h100 + 32'(nx), nx % 4 == 3);
        end
        if (m_ready) nx++;
      end
      checks++;
      if (int'(dut.occ) + int'(dut.inflight) > 2) begin
        errors++;
        $display("FAIL stall_occ k=%0d: got occ+inflight=%0d expected <=2", k, int'(dut.occ) + int'(dut.inflight));
      end
      @(negedge clk);
    end
    checks++;
    if (nx !== 8 || rd_ptr - base_rd !== 8 || pkt_cnt !== 16'd2) begin
      errors++;
      $display("FAIL stall_count: got xfers=%0d pops=%0d pkt=%0d expected 8/8/2", nx, rd_ptr - base_rd, pkt_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      exp = {(i % 4 == 3) ? 1'b1 : 1'b0, 32'h100 + 32'(i)};
      checks++;
      if (obs[base_obs + i] !== exp) begin
        errors++;
        $display("FAIL stall_order i=%0d: got %h expected %h", i, obs[base_obs + i], exp);
      end
    end
  endtask

  task automatic test_enable();
    int base_rd;
    int base_obs;
    logic [32:0] exp;
    do_reset();
    base_rd = rd_ptr;
    base_obs = n_obs;
    for (int i = 0; i < 6; i++) push(32'h100 + 32'(i));
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m_ready = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h100 || fifo_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL en_third_pop: got v=%b data=%h rd=%b expected 1/100/1", m_valid, m_data, fifo_rd_en);
    end
    @(negedge clk);
    enable = 1'b0;
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b1 || m_data !== 32'h101) begin
        errors++;
        $display("FAIL en_hold k=%0d: got rd=%b v=%b data=%h expected 0/1/101", k, fifo_rd_en, m_valid, m_data);
      end
      @(negedge clk);
    end
    checks++;
    if (rd_ptr - base_rd !== 3) begin
      errors++;
      $display("FAIL en_pops: got %0d expected 3", rd_ptr - base_rd);
    end
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (fifo_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL en_drain_rd k=%0d: got %b expected 0", k, fifo_rd_en);
      end
      @(negedge clk);
    end
    checks++;
    if (n_obs - base_obs !== 3) begin
      errors++;
      $display("FAIL en_drain_count: got %0d expected 3", n_obs - base_obs);
    end
    enable = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (n_obs - base_obs !== 6 || pkt_cnt !== 16'd1) begin
      errors++;
      $display("FAIL en_resume_count: got words=%0d pkt=%0d expected 6/1", n_obs - base_obs, pkt_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      exp = {(i == 3) ? 1'b1 : 1'b0, 32'h100 + 32'(i)};
      checks++;
      if (obs[base_obs + i] !== exp) begin
        errors++;
        $display("FAIL en_order i=%0d: got %h expected %h", i, obs[base_obs + i], exp);
      end
    end
  endtask

  task automatic test_empty_gap();
    int base_obs;
    logic [32:0] exp;
    do_reset();
    base_obs = n_obs;
    m_ready = 1'b1;
    push(32'h200);
    push(32'h201);
    enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (k >= 4) begin
        checks++;
        if (m_valid !== 1'b0 || m_last !== 1'b0) begin
          errors++;
          $display("FAIL gap_idle k=%0d: got v=%b l=%b expected 0/0", k, m_valid, m_last);
        end
      end
      @(negedge clk);
    end
    push(32'h202);
    push(32'h203);
    repeat (8) @(negedge clk);
    checks++;
    if (n_obs - base_obs !== 4 || pkt_cnt !== 16'd1) begin
      errors++;
      $display("FAIL gap_count: got words=%0d pkt=%0d expected 4/1", n_obs - base_obs, pkt_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      exp = {(i == 3) ? 1'b1 : 1'b0, 32'h200 + 32'(i)};
      checks++;
      if (obs[base_obs + i] !== exp) begin
        errors++;
        $display("FAIL gap_order i=%0d: got %h expected %h", i, obs[base_obs + i], exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base_obs;
    do_reset();
    for (int i = 0; i < 6; i++) push(32'h300 + 32'(i));
    m_ready = 1'b1;
    enable = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (pkt_cnt !== 16'd1 || m_valid !== 1'b1 || m_data !== 32'h304) begin
      errors++;
      $display("FAIL mid_pre: got pkt=%0d v=%b data=%h expected 1/1/304", pkt_cnt, m_valid, m_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_last, fifo_rd_en} !== 3'b000 || m_data !== 32'h0 || pkt_cnt !== 16'h0) begin
      errors++;
      $display("FAIL mid_zero: got v/l/rd=%b data=%h pkt=%0d expected 000/0/0", {m_valid, m_last, fifo_rd_en}, m_data, pkt_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    base_obs = n_obs;
    push(32'h306);
    repeat (5) @(negedge clk);
    checks++;
    if (n_obs - base_obs !== 1 || obs[base_obs] !== {1'b0, 32'h306} || pkt_cnt !== 16'h0) begin
      errors++;
      $display("FAIL mid_restart: got words=%0d first=%h pkt=%0d expected 1/0_00000306/0", n_obs - base_obs, obs[base_obs], pkt_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_enable();
    test_empty_gap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
